rx_eye_trainer: RTL and testbench

Fabric-side training controller sitting directly upstream of the RX lane controller's dynamic delay-line port. It sweeps the RX DQS delay line one tap at a time and qualifies each tap with the IOD eye-monitor error flags. It then finds the first contiguous passing window and parks the delay line at the window centre. It owns DELAY_LINE_SEL/LOAD/DIRECTION/MOVE, HS_IO_CLK_PAUSE and EYE_MONITOR_WIDTH_IN of the lane controller and reports status to the link-bring-up logic.

---
 rtl/rx_train_pkg.sv | 42 ++++
 rtl/rx_dl_step_seq.sv | 92 +++++++++
 rtl/rx_eye_trainer.sv | 242 ++++++++++++++++++++++++
 tb/tb_rx_eye_trainer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rx_train_pkg.sv
// ---------------------------------------------------------------------------
// rx_train_pkg
// Types and constants shared by the RX eye trainer and its delay-line step
// sequencer: FSM state encoding, the 8-bit tap index type, sequence phases,
// and the LOAD/MOVE kind and direction codes.
// ---------------------------------------------------------------------------
package rx_train_pkg;

   // Delay-line tap index; NUM_TAPS is at most 256, so 8 bits always suffice.
   typedef logic [7:0] tap_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_SAMPLE,
      ST_EVAL,
      ST_STEP_UP,
      ST_STEP_DN,
      ST_DONE,
      ST_FAIL
   } state_e;

   // Phases of one 3-cycle delay-line sequence. PAUSE covers PRE, STROBE
   // and POST; the LOAD/MOVE strobe is high during STROBE only.
   localparam logic [1:0] PH_IDLE   = 2'd0;
   localparam logic [1:0] PH_PRE    = 2'd1;
   localparam logic [1:0] PH_STROBE = 2'd2;
   localparam logic [1:0] PH_POST   = 2'd3;

   // Sequence kind: reset the line to its base value, or step it one tap.
   localparam logic SEQ_LOAD = 1'b0;
   localparam logic SEQ_MOVE = 1'b1;

   // Delay-line step direction.
   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // Width of the settle/sample cycle counter.
   localparam int CNT_W = 16;

endpackage

// File: rtl/rx_dl_step_seq.sv
// ---------------------------------------------------------------------------
// rx_dl_step_seq
// Generates one 3-cycle delay-line sequence per request:
//   cycle 1: PAUSE
//   cycle 2: PAUSE + LOAD or MOVE
//   cycle 3: PAUSE, with o_done high
// DIRECTION is latched at the request and held for all three cycles.
// A new request accepted in the done cycle starts the next sequence on the
// following cycle, so step-downs can run back-to-back with PAUSE held high.
//
// Ports
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req          : start a sequence (accepted when idle or in the done cycle)
//   i_kind         : SEQ_LOAD or SEQ_MOVE
//   i_dir          : direction for this sequence (DIR_UP / DIR_DN)
//   o_done         : high in the last cycle of the sequence
//   o_pause        : HS_IO_CLK_PAUSE
//   o_load         : DELAY_LINE_LOAD strobe
//   o_move         : DELAY_LINE_MOVE strobe
//   o_dir          : DELAY_LINE_DIRECTION
// ---------------------------------------------------------------------------
module rx_dl_step_seq
   import rx_train_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_req,
   input  logic i_kind,
   input  logic i_dir,
   output logic o_done,
   output logic o_pause,
   output logic o_load,
   output logic o_move,
   output logic o_dir
);

   logic [1:0] r_phase;
   logic       r_kind;
   logic       r_done;
   logic       r_pause;
   logic       r_load;
   logic       r_move;
   logic       r_dir;

   // NOTE: state is assigned with non-blocking (<=) so every register samples
   // the pre-edge values, independent of statement order inside the block.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_phase <= PH_IDLE;
         r_kind  <= SEQ_LOAD;
         r_done  <= 1'b0;
         r_pause <= 1'b0;
         r_load  <= 1'b0;
         r_move  <= 1'b0;
         r_dir   <= 1'b0;
      end else begin
         r_load <= 1'b0;
         r_move <= 1'b0;
         r_done <= 1'b0;
         case (r_phase)
            PH_IDLE, PH_POST: begin
               if (i_req) begin
                  r_phase <= PH_PRE;
                  r_pause <= 1'b1;
                  r_kind  <= i_kind;
                  r_dir   <= i_dir;
               end else begin
                  r_phase <= PH_IDLE;
                  r_pause <= 1'b0;
               end
            end
            PH_PRE: begin
               r_phase <= PH_STROBE;
               r_load  <= (r_kind == SEQ_LOAD);
               r_move  <= (r_kind == SEQ_MOVE);
            end
            PH_STROBE: begin
               r_phase <= PH_POST;
               r_done  <= 1'b1;
            end
            default: r_phase <= PH_IDLE;
         endcase
      end
   end

   assign o_done  = r_done;
   assign o_pause = r_pause;
   assign o_load  = r_load;
   assign o_move  = r_move;
   assign o_dir   = r_dir;

endmodule

// File: rtl/rx_eye_trainer.sv
// ---------------------------------------------------------------------------
// rx_eye_trainer
// Sweeps the RX DQS delay line upward one tap at a time from its base value,
// qualifies each tap with the eye-monitor early/late flags, finds the first
// contiguous passing window and steps the line back down to the window
// centre.
//
// Ports
//   FAB_CLK, ARST_N              : clock, asynchronous active-low reset
//   START                        : one-cycle (re)train request, ignored while BUSY
//   EYE_EARLY, EYE_LATE          : eye-monitor error flags
//   RX_DELAY_LINE_OUT_OF_RANGE   : delay line at its end stop
//   DELAY_LINE_SEL/LOAD/DIRECTION/MOVE, HS_IO_CLK_PAUSE : lane-controller port
//   EYE_MONITOR_WIDTH_OUT_CFG    : constant eye-monitor width
//   BUSY, DONE, FAIL             : training status
//   TAP_COUNT                    : current delay-line tap index
//   EYE_WIDTH                    : width of the detected window (0 if none)
// ---------------------------------------------------------------------------
module rx_eye_trainer
   import rx_train_pkg::*;
#(
   parameter int         NUM_TAPS      = 128,
   parameter int         SETTLE_CYCLES = 8,
   parameter int         SAMPLE_CYCLES = 64,
   parameter int         MIN_EYE       = 4,
   parameter logic [2:0] EYE_MON_WIDTH = 3'b011
) (
   input  logic       FAB_CLK,
   input  logic       ARST_N,
   input  logic       START,
   input  logic       EYE_EARLY,
   input  logic       EYE_LATE,
   input  logic       RX_DELAY_LINE_OUT_OF_RANGE,
   output logic       DELAY_LINE_SEL,
   output logic       DELAY_LINE_LOAD,
   output logic       DELAY_LINE_DIRECTION,
   output logic       DELAY_LINE_MOVE,
   output logic       HS_IO_CLK_PAUSE,
   output logic [2:0] EYE_MONITOR_WIDTH_OUT_CFG,
   output logic       BUSY,
   output logic       DONE,
   output logic       FAIL,
   output logic [7:0] TAP_COUNT,
   output logic [7:0] EYE_WIDTH
);

   localparam tap_t LAST_TAP = tap_t'(NUM_TAPS - 1);

   state_e           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   logic             r_busy;
   logic             r_done;
   logic             r_fail;
   tap_t             r_tap;
   tap_t             r_eye_start;
   logic             r_eye_found;
   tap_t             r_eye_width;
   tap_t             r_target;

   logic w_seq_req;
   logic w_seq_kind;
   logic w_seq_dir;
   logic w_seq_done;

   logic w_tap_fail;
   logic w_is_last;
   logic w_close;
   logic w_abort;
   logic w_eye_ok;
   tap_t w_start;
   tap_t w_end;
   tap_t w_width;
   tap_t w_target;
   tap_t w_tap_dec;

   // Per-tap evaluation. The window start is the current tap when the first
   // passing tap is the one that also closes the window (pass at the last tap).
   // NOTE: every signal written here gets a value on every path; a missing
   // default in always_comb would infer a latch.
   always_comb begin
      w_tap_fail = r_err | RX_DELAY_LINE_OUT_OF_RANGE;
      w_is_last  = (r_tap == LAST_TAP);
      w_start    = r_eye_found ? r_eye_start : r_tap;
      w_end      = w_tap_fail ? (r_tap - 8'd1) : r_tap;
      w_width    = w_end - w_start + 8'd1;
      w_target   = w_start + ((w_width - 8'd1) >> 1);
      w_close    = r_eye_found ? (w_tap_fail | w_is_last) : (~w_tap_fail & w_is_last);
      w_abort    = ~r_eye_found & w_tap_fail & (RX_DELAY_LINE_OUT_OF_RANGE | w_is_last);
      w_eye_ok   = (w_width >= tap_t'(MIN_EYE));
      w_tap_dec  = r_tap - 8'd1;
   end

   // Sequencer requests are raised in the cycle the FSM decides to move, so
   // PAUSE rises together with the state change rather than a cycle later.
   always_comb begin
      w_seq_req  = 1'b0;
      w_seq_kind = SEQ_MOVE;
      w_seq_dir  = DIR_UP;
      case (r_state)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (START) begin
               w_seq_req  = 1'b1;
               w_seq_kind = SEQ_LOAD;
            end
         end
         ST_EVAL: begin
            if (w_close) begin
               if (w_eye_ok && (w_target != r_tap)) begin
                  w_seq_req = 1'b1;
                  w_seq_dir = DIR_DN;
               end
            end else if (!w_abort) begin
               w_seq_req = 1'b1;
            end
         end
         ST_STEP_DN: begin
            if (w_seq_done && (w_tap_dec != r_target)) begin
               w_seq_req = 1'b1;
               w_seq_dir = DIR_DN;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_fail      <= 1'b0;
         r_tap       <= '0;
         r_eye_start <= '0;
         r_eye_found <= 1'b0;
         r_eye_width <= '0;
         r_target    <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
               if (START) begin
                  r_state     <= ST_LOAD;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_fail      <= 1'b0;
                  r_eye_width <= '0;
                  r_tap       <= '0;
                  r_eye_start <= '0;
                  r_eye_found <= 1'b0;
               end
            end
            ST_LOAD, ST_STEP_UP: begin
               if (w_seq_done) begin
                  r_state <= ST_SETTLE;
                  r_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
               end
            end
            ST_SETTLE: begin
               if (r_cnt == '0) begin
                  r_state <= ST_SAMPLE;
                  r_cnt   <= CNT_W'(SAMPLE_CYCLES - 1);
                  r_err   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_SAMPLE: begin
               // Sticky: a single flagged cycle anywhere in the window fails the tap.
               r_err <= r_err | EYE_EARLY | EYE_LATE;
               if (r_cnt == '0) begin
                  r_state <= ST_EVAL;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_EVAL: begin
               if (!w_tap_fail && !r_eye_found) begin
                  r_eye_start <= r_tap;
                  r_eye_found <= 1'b1;
               end
               if (w_close) begin
                  r_eye_width <= w_width;
                  if (!w_eye_ok) begin
                     r_state <= ST_FAIL;
                     r_busy  <= 1'b0;
                     r_fail  <= 1'b1;
                  end else if (w_target == r_tap) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_target <= w_target;
                     r_state  <= ST_STEP_DN;
                  end
               end else if (w_abort) begin
                  r_state <= ST_FAIL;
                  r_busy  <= 1'b0;
                  r_fail  <= 1'b1;
               end else begin
                  r_tap   <= r_tap + 8'd1;
                  r_state <= ST_STEP_UP;
               end
            end
            ST_STEP_DN: begin
               if (w_seq_done) begin
                  r_tap <= w_tap_dec;
                  if (w_tap_dec == r_target) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   rx_dl_step_seq u_step_seq (
      .i_clk   (FAB_CLK),
      .i_rst_n (ARST_N),
      .i_req   (w_seq_req),
      .i_kind  (w_seq_kind),
      .i_dir   (w_seq_dir),
      .o_done  (w_seq_done),
      .o_pause (HS_IO_CLK_PAUSE),
      .o_load  (DELAY_LINE_LOAD),
      .o_move  (DELAY_LINE_MOVE),
      .o_dir   (DELAY_LINE_DIRECTION)
   );

   assign DELAY_LINE_SEL            = r_busy;
   assign BUSY                      = r_busy;
   assign DONE                      = r_done;
   assign FAIL                      = r_fail;
   assign TAP_COUNT                 = r_tap;
   assign EYE_WIDTH                 = r_eye_width;
   assign EYE_MONITOR_WIDTH_OUT_CFG = EYE_MON_WIDTH;

endmodule

// File: tb/tb_rx_eye_trainer.sv
// ---------------------------------------------------------------------------
// tb_rx_eye_trainer
// Directed bench for rx_eye_trainer. A behavioural delay-line model follows
// the LOAD/MOVE strobes and drives the eye-monitor flags from a per-test
// passing window, optional end-stop tap and optional one-cycle glitch tap.
// ---------------------------------------------------------------------------
module tb_rx_eye_trainer;

   logic       FAB_CLK;
   logic       ARST_N;
   logic       START;
   logic       EYE_EARLY;
   logic       EYE_LATE;
   logic       RX_DELAY_LINE_OUT_OF_RANGE;
   logic       DELAY_LINE_SEL;
   logic       DELAY_LINE_LOAD;
   logic       DELAY_LINE_DIRECTION;
   logic       DELAY_LINE_MOVE;
   logic       HS_IO_CLK_PAUSE;
   logic [2:0] EYE_MONITOR_WIDTH_OUT_CFG;
   logic       BUSY;
   logic       DONE;
   logic       FAIL;
   logic [7:0] TAP_COUNT;
   logic [7:0] EYE_WIDTH;

   int n_checks = 0;
   int n_fail   = 0;

   // Delay-line model and stimulus configuration.
   int m_tap      = 0;
   int age        = 0;
   int n_load     = 0;
   int n_up       = 0;
   int n_dn       = 0;
   int n_viol     = 0;
   int pass_lo    = 0;
   int pass_hi    = -1;
   int oor_tap    = 1000;
   int glitch_tap = -1;

   rx_eye_trainer dut (
      .FAB_CLK                    (FAB_CLK),
      .ARST_N                     (ARST_N),
      .START                      (START),
      .EYE_EARLY                  (EYE_EARLY),
      .EYE_LATE                   (EYE_LATE),
      .RX_DELAY_LINE_OUT_OF_RANGE (RX_DELAY_LINE_OUT_OF_RANGE),
      .DELAY_LINE_SEL             (DELAY_LINE_SEL),
      .DELAY_LINE_LOAD            (DELAY_LINE_LOAD),
      .DELAY_LINE_DIRECTION       (DELAY_LINE_DIRECTION),
      .DELAY_LINE_MOVE            (DELAY_LINE_MOVE),
      .HS_IO_CLK_PAUSE            (HS_IO_CLK_PAUSE),
      .EYE_MONITOR_WIDTH_OUT_CFG  (EYE_MONITOR_WIDTH_OUT_CFG),
      .BUSY                       (BUSY),
      .DONE                       (DONE),
      .FAIL                       (FAIL),
      .TAP_COUNT                  (TAP_COUNT),
      .EYE_WIDTH                  (EYE_WIDTH)
   );

   initial FAB_CLK = 1'b0;
   always #5 FAB_CLK = ~FAB_CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Delay-line model: follows strobes at the falling edge and drives the
   // eye-monitor flags for the tap the line is currently sitting on.
   initial begin
      EYE_EARLY                  = 1'b0;
      EYE_LATE                   = 1'b0;
      RX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
      forever begin
         @(negedge FAB_CLK);
         if (DELAY_LINE_LOAD) begin
            m_tap = 0;
            age   = 0;
            n_load++;
         end else if (DELAY_LINE_MOVE) begin
            if (DELAY_LINE_DIRECTION) begin
               m_tap++;
               n_up++;
            end else begin
               m_tap--;
               n_dn++;
            end
            age = 0;
         end else begin
            age++;
         end
         if ((DELAY_LINE_LOAD || DELAY_LINE_MOVE) && !HS_IO_CLK_PAUSE) n_viol++;
         if (DELAY_LINE_LOAD && DELAY_LINE_MOVE) n_viol++;
         if (DELAY_LINE_SEL != BUSY) n_viol++;
         if (EYE_MONITOR_WIDTH_OUT_CFG != 3'b011) n_viol++;
         EYE_EARLY                  = (m_tap < pass_lo) || (m_tap > pass_hi);
         EYE_LATE                   = (m_tap == glitch_tap) && (age == 30);
         RX_DELAY_LINE_OUT_OF_RANGE = (m_tap >= oor_tap);
      end
   end

   // Issue START for one cycle; returns at the falling edge of the first
   // cycle after START was sampled and checks the immediate response.
   task automatic pulse_start(input string tag);
      @(negedge FAB_CLK);
      START = 1'b1;
      @(negedge FAB_CLK);
      START = 1'b0;
      check($sformatf("%s.busy_rise", tag), BUSY, 1);
      check($sformatf("%s.pause_rise", tag), HS_IO_CLK_PAUSE, 1);
      check($sformatf("%s.status_clr", tag), {DONE, FAIL}, 0);
   endtask

   task automatic run_case(input string tag, input int lo, input int hi, input int oor,
                           input int glitch, input bit spam,
                           input int exp_done, input int exp_fail, input int exp_width,
                           input int exp_tap, input int exp_up, input int exp_dn,
                           input int exp_lat);
      int cyc;
      pass_lo    = lo;
      pass_hi    = hi;
      oor_tap    = oor;
      glitch_tap = glitch;
      n_load     = 0;
      n_up       = 0;
      n_dn       = 0;
      n_viol     = 0;
      pulse_start(tag);
      cyc = 0;
      while (!(DONE || FAIL) && cyc < 12000) begin
         @(posedge FAB_CLK);
         cyc++;
         @(negedge FAB_CLK);
         START = spam && ((cyc % 500) == 250);
      end
      START = 1'b0;
      check($sformatf("%s.finished", tag), DONE | FAIL, 1);
      check($sformatf("%s.latency", tag), cyc, exp_lat);
      check($sformatf("%s.done", tag), DONE, exp_done);
      check($sformatf("%s.fail", tag), FAIL, exp_fail);
      check($sformatf("%s.busy", tag), BUSY, 0);
      check($sformatf("%s.eye_width", tag), EYE_WIDTH, exp_width);
      check($sformatf("%s.tap_count", tag), TAP_COUNT, exp_tap);
      check($sformatf("%s.line_tap", tag), m_tap, exp_tap);
      check($sformatf("%s.loads", tag), n_load, 1);
      check($sformatf("%s.up_moves", tag), n_up, exp_up);
      check($sformatf("%s.dn_moves", tag), n_dn, exp_dn);
      check($sformatf("%s.protocol", tag), n_viol, 0);
   endtask

   initial begin
      int guard;
      ARST_N = 1'b0;
      START  = 1'b0;
      @(negedge FAB_CLK);
      check("reset.outputs",
            {DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE,
             HS_IO_CLK_PAUSE, BUSY, DONE, FAIL, TAP_COUNT, EYE_WIDTH}, 0);
      check("reset.cfg", EYE_MONITOR_WIDTH_OUT_CFG, 3);
      @(negedge FAB_CLK);
      ARST_N = 1'b1;
      repeat (2) @(negedge FAB_CLK);

      //        tag    lo   hi   oor  glitch spam done fail width tap up  dn  latency
      run_case("eye20", 20,  39, 1000, -1,   0,   1,   0,   20,   29, 40, 11, 3149);
      run_case("noeye", 200, 0,  1000, -1,   0,   0,   1,   0,   127, 127, 0, 9728);
      run_case("narrow",10,  12, 1000, -1,   0,   0,   1,   3,    13, 13,  0, 1064);
      run_case("oor",   45, 127, 50,   -1,   0,   1,   0,   5,    47, 50,  3, 3885);
      run_case("glitch", 0, 127, 1000, 30,   1,   1,   0,   30,   14, 30, 16, 2404);

      // Reset in the middle of sampling tap 15.
      pass_lo = 20;
      pass_hi = 39;
      oor_tap = 1000;
      glitch_tap = -1;
      pulse_start("arst");
      guard = 0;
      while (!(m_tap == 15 && age >= 20 && age <= 60) && guard < 3000) begin
         @(negedge FAB_CLK);
         guard++;
      end
      check("arst.reached_tap15", m_tap, 15);
      check("arst.busy_before", BUSY, 1);
      ARST_N = 1'b0;
      #1;
      check("arst.outputs",
            {DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE,
             HS_IO_CLK_PAUSE, BUSY, DONE, FAIL, TAP_COUNT, EYE_WIDTH}, 0);
      check("arst.cfg", EYE_MONITOR_WIDTH_OUT_CFG, 3);
      repeat (2) @(negedge FAB_CLK);
      ARST_N = 1'b1;
      @(negedge FAB_CLK);
      check("arst.idle_after", {BUSY, HS_IO_CLK_PAUSE, TAP_COUNT}, 0);
      run_case("restart", 20, 39, 1000, -1, 0, 1, 0, 20, 29, 40, 11, 3149);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
